// File: rtl/multdiv_iter_if.sv
// Operand/result bundle shared between the execute stage and the iterative
// multiply/divide unit.
//
// Signals:
//   data_operandA / data_operandB : two's-complement operands, sampled on start
//   ctrl_MULT / ctrl_DIV          : one-cycle start pulses (MULT has priority)
//   data_result                   : product low word or truncated quotient
//   data_exception                : overflow or divide-by-zero, valid with RDY
//   data_resultRDY                : one-cycle pulse marking result valid
//   data_busy                     : unit is working; pipeline should stall
//
// Modports:
//   master : the pipeline side, drives operands and start pulses
//   slave  : the unit itself
interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             data_busy;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  data_busy
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output data_busy
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit for the execute stage.
// MULT uses radix-2 Booth shift-add; DIV uses restoring division on operand
// magnitudes followed by a sign fix-up. Both take WIDTH iterations plus one
// edge to register the result, so the ready pulse appears a fixed 33 edges
// after the start pulse for WIDTH=32.
//
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset; aborts any operation in flight
//   bus     : multdiv_iter_if slave modport (operands, start pulses, result,
//             exception, ready pulse, busy)
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  multdiv_iter_if.slave        bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_mult_q, is_mult_d;

  // Booth datapath: accumulator is one bit wider than the operands so that
  // subtracting the most negative multiplicand cannot overflow.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   m_q, m_d;

  // Restoring divider datapath: quotient register starts as the dividend
  // magnitude and is shifted out MSB-first while quotient bits shift in.
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             neg_q, neg_d;
  logic             div0_q, div0_d;
  logic             divovf_q, divovf_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic                    start;
  logic [WIDTH-1:0]        mag_a;
  logic [WIDTH-1:0]        mag_b;
  logic [WIDTH:0]          booth_sum;
  logic signed [2*WIDTH+1:0] booth_vec;
  logic signed [2*WIDTH+1:0] booth_shift;
  logic [WIDTH+1:0]        div_shift;
  logic [WIDTH+1:0]        div_diff;
  logic [WIDTH+1:0]        prod_hi;
  logic [WIDTH-1:0]        quo_fixed;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  // Magnitudes are unsigned, so the most negative value maps cleanly to
  // 2^(WIDTH-1) without needing a special case.
  assign mag_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1))
                                            : bus.data_operandA;
  assign mag_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1))
                                            : bus.data_operandB;

  // State, datapath registers and result/exception outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      is_mult_q <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dmag_q    <= '0;
      neg_q     <= 1'b0;
      div0_q    <= 1'b0;
      divovf_q  <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_mult_q <= is_mult_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dmag_q    <= dmag_d;
      neg_q     <= neg_d;
      div0_q    <= div0_d;
      divovf_q  <= divovf_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
    end
  end

  // Next-state and datapath logic. A start pulse is handled last so it
  // overrides whatever the current state would do, which gives the silent
  // restart behaviour.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_mult_d = is_mult_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dmag_d    = dmag_q;
    neg_d     = neg_q;
    div0_d    = div0_q;
    divovf_d  = divovf_q;
    result_d  = result_q;
    exc_d     = exc_q;

    booth_sum   = acc_q;
    booth_vec   = '0;
    booth_shift = '0;
    div_shift   = {rem_q, quo_q[WIDTH-1]};
    div_diff    = div_shift - {2'b00, dmag_q};
    prod_hi     = {acc_q, q_q[WIDTH-1]};
    quo_fixed   = neg_q ? (~quo_q + WIDTH'(1)) : quo_q;

    case (state_q)
      RUN: begin
        // count reaches WIDTH after the last iteration; the following edge
        // only registers the result.
        if (count_q == CW'(WIDTH)) begin
          if (is_mult_q) begin
            result_d = q_q;
            exc_d    = !((&prod_hi) || !(|prod_hi));
          end else begin
            result_d = div0_q ? '0 : quo_fixed;
            exc_d    = div0_q | divovf_q;
          end
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
          if (is_mult_q) begin
            case ({q_q[0], qm1_q})
              2'b01:   booth_sum = acc_q + m_q;
              2'b10:   booth_sum = acc_q - m_q;
              default: booth_sum = acc_q;
            endcase
            booth_vec   = {booth_sum, q_q, qm1_q};
            booth_shift = booth_vec >>> 1;
            acc_d       = booth_shift[2*WIDTH+1:WIDTH+1];
            q_d         = booth_shift[WIDTH:1];
            qm1_d       = booth_shift[0];
          end else begin
            if (!div_diff[WIDTH+1]) begin
              rem_d = div_diff[WIDTH:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = div_shift[WIDTH:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      state_d   = RUN;
      count_d   = '0;
      is_mult_d = bus.ctrl_MULT;
      acc_d     = '0;
      q_d       = bus.data_operandB;
      qm1_d     = 1'b0;
      m_d       = {bus.data_operandA[WIDTH-1], bus.data_operandA};
      rem_d     = '0;
      quo_d     = mag_a;
      dmag_d    = mag_b;
      neg_d     = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      div0_d    = (bus.data_operandB == '0);
      // Most negative / -1 is the only quotient that does not fit.
      divovf_d  = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (bus.data_operandB == '1);
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.data_busy      = (state_q != IDLE);

endmodule
